branch_resolve_unit: RTL

- Sits downstream of the Gshare predictor and spans IF→EX of the 5-stage pipeline.
- Records each fetched PC's prediction (taken, target) in a small in-order FIFO.
- Pops the entry when that instruction leaves EX, compares it with the actual outcome, and drives redirect/flush to the PC mux.
- Drives the registered update_* bus consumed by the predictor.

---
 rtl/bru_pkg.sv | 16 +
 rtl/pred_fifo.sv | 65 ++++++
 rtl/branch_resolve_unit.sv | 123 ++++++++++++
 3 files changed

// File: rtl/bru_pkg.sv
// Shared types and defaults for the branch resolve unit.
// Prediction entry layout and FIFO sizing.
package bru_pkg;

    localparam int DEPTH_DEF    = 4;
    localparam int PTR_BITS_DEF = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic        pred_taken;
        logic [31:0] pred_target;
    } pred_entry_t;

    localparam pred_entry_t PRED_ENTRY_RST = '0;

endpackage

// File: rtl/pred_fifo.sv
// In-order FIFO of fetch-time predictions.
// Push and pop together are legal when full.
module pred_fifo
    import bru_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEF,
    parameter int PTR_BITS = PTR_BITS_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push,
    input  logic                pop,
    input  logic                clear,
    input  pred_entry_t         din,
    output pred_entry_t         head,
    output logic                full,
    output logic                empty,
    output logic [PTR_BITS:0]   count,
    output logic                overflow
);

    localparam logic [PTR_BITS:0] FULL_CNT =
        (PTR_BITS+1)'(DEPTH);

    pred_entry_t         mem [DEPTH];
    logic [PTR_BITS-1:0] rd_ptr;
    logic [PTR_BITS-1:0] wr_ptr;
    logic                do_pop;
    logic                do_push;
    logic                wr_en;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign wr_en    = do_push & ~clear;
    assign overflow = push & full & ~do_pop & ~clear;
    assign head     = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; clear wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage, written at the tail.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves predictions at EX: redirect, flush, predictor update.
// Define BRU_STATS_EN to build the branch/mispredict counters.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEF,
    parameter int PTR_BITS = PTR_BITS_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_push,
    input  logic [31:0] fetch_pc,
    input  logic        fetch_pred_taken,
    input  logic [31:0] fetch_pred_target,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic        ex_is_jump,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        fifo_full,
    output logic        update_valid,
    output logic [31:0] update_pc,
    output logic [31:0] update_target,
    output logic        update_taken,
    output logic        protocol_err,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
);

    pred_entry_t       din;
    pred_entry_t       head;
    logic              q_full;
    logic              q_empty;
    logic [PTR_BITS:0] q_count;
    logic              q_ovf;
    logic              pop;
    logic              underflow;
    logic              is_ctrl;
    logic              act_taken;
    logic              mispredict;
    logic [31:0]       correct_pc;

    assign din = '{pc:          fetch_pc,
                   pred_taken:  fetch_pred_taken,
                   pred_target: fetch_pred_target};

    pred_fifo #(
        .DEPTH    (DEPTH),
        .PTR_BITS (PTR_BITS)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fetch_push),
        .pop      (pop),
        .clear    (mispredict),
        .din      (din),
        .head     (head),
        .full     (q_full),
        .empty    (q_empty),
        .count    (q_count),
        .overflow (q_ovf)
    );

    assign pop        = ex_valid & ~q_empty & ~reset;
    assign underflow  = ex_valid & (q_count == '0);
    assign is_ctrl    = ex_is_branch | ex_is_jump;
    assign act_taken  = ex_taken & is_ctrl;
    assign correct_pc = act_taken ? ex_target
                                  : head.pc + 32'd4;

    assign mispredict = pop &
        ((act_taken != head.pred_taken) |
         (act_taken & (ex_target != head.pred_target)));

    assign redirect_valid = mispredict;
    assign flush          = mispredict;
    assign redirect_pc    = correct_pc;
    assign fifo_full      = q_full & ~reset;

    // Predictor update bus, one cycle after a control-op pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            update_valid  <= 1'b0;
            update_pc     <= '0;
            update_target <= '0;
            update_taken  <= 1'b0;
        end else if (pop && is_ctrl) begin
            update_valid  <= 1'b1;
            update_pc     <= head.pc;
            update_target <= ex_target;
            update_taken  <= act_taken;
        end else begin
            update_valid  <= 1'b0;
        end
    end

    // Sticky overflow/underflow flag.
    always_ff @(posedge clk) begin
        if (reset)                     protocol_err <= 1'b0;
        else if (q_ovf || underflow)   protocol_err <= 1'b1;
    end

`ifdef BRU_STATS_EN
    // Resolved control ops and their mispredicts.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (pop && is_ctrl) begin
            stat_branches <= stat_branches + 32'd1;
            if (mispredict)
                stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
`endif

endmodule
